// File: rtl/microcode_sequencer_pkg.sv
// Shared types for the microcode sequencer: register and phase encodings, micro-op layout, FSM states.
package microcode_sequencer_pkg;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned UOP_W        = 16;
    localparam int unsigned MAX_UOPS     = 16;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned ALU_W        = 4;
    localparam int unsigned UOP_LAST_BIT = 15;
    localparam int unsigned STEP_W       = $clog2(MAX_UOPS) + 1;

    // REG_ALU is not a writable destination, so parking both selectors on it is a safe idle.
    typedef enum logic [REG_W-1:0] {
        REG_A   = 5'd0,
        REG_B   = 5'd1,
        REG_C   = 5'd2,
        REG_D   = 5'd3,
        REG_SP  = 5'd4,
        REG_PC  = 5'd5,
        REG_MAR = 5'd6,
        REG_MDR = 5'd7,
        REG_IR  = 5'd8,
        REG_ALU = 5'd31
    } reg_type;

    typedef enum logic [1:0] {
        CYCLE_NOOP      = 2'd0,
        CYCLE_REG_FETCH = 2'd1,
        CYCLE_ALU       = 2'd2,
        CYCLE_REG_WRITE = 2'd3
    } microcode_cycle;

    typedef struct packed {
        logic             last;
        logic [REG_W-1:0] in_sel;
        logic [REG_W-1:0] out_sel;
        logic             rsvd;
        logic [ALU_W-1:0] alu_op;
    } uop_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DECODE = 3'd2,
        ST_FETCH  = 3'd3,
        ST_ALU    = 3'd4,
        ST_WRITE  = 3'd5
    } seq_state;

endpackage

// File: rtl/microcode_sequencer.sv
// Steps micro-op programs out of a synchronous microcode ROM and drives the register/ALU phases.
// Define UCODE_PREFETCH_EN to overlap the next ROM read with the ALU phase (3 cycles per chained op).
module microcode_sequencer
    import microcode_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic              i_stall,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [UOP_W-1:0]  i_rom_data,
    output logic [1:0]        o_current_cycle,
    output logic [REG_W-1:0]  o_bus_input_selector,
    output logic [REG_W-1:0]  o_bus_output_selector,
    output logic [ALU_W-1:0]  o_alu_op,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    seq_state            r_state;
    uop_t                r_uop;
    logic [ADDR_W-1:0]   r_pc;
    logic [STEP_W-1:0]   r_step;

    uop_t                w_rom_uop;
    logic                w_freeze;
    logic                w_last_step;
    logic                w_unused_rsvd;

    assign w_rom_uop     = uop_t'(i_rom_data);
    assign w_freeze      = i_stall && (r_state != ST_IDLE);
    assign w_last_step   = (r_step == STEP_W'(MAX_UOPS - 1));
    assign w_unused_rsvd = r_uop.rsvd;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state               <= ST_IDLE;
            r_uop                 <= '0;
            r_pc                  <= '0;
            r_step                <= '0;
            o_rom_addr            <= '0;
            o_current_cycle       <= CYCLE_NOOP;
            o_bus_input_selector  <= REG_ALU;
            o_bus_output_selector <= REG_ALU;
            o_alu_op              <= '0;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
            o_overrun             <= 1'b0;
        end else begin
            // done is a transition pulse, so it drops even while frozen
            o_done <= 1'b0;
            if (!w_freeze) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state    <= ST_ADDR;
                            r_pc       <= i_start_addr;
                            o_rom_addr <= i_start_addr;
                            r_step     <= '0;
                            o_busy     <= 1'b1;
                            o_overrun  <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        r_state <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        r_state               <= ST_FETCH;
                        r_uop                 <= w_rom_uop;
                        o_current_cycle       <= CYCLE_REG_FETCH;
                        o_bus_input_selector  <= w_rom_uop.in_sel;
                        o_bus_output_selector <= w_rom_uop.out_sel;
                        o_alu_op              <= w_rom_uop.alu_op;
                    end
                    ST_FETCH: begin
                        r_state               <= ST_ALU;
                        o_current_cycle       <= CYCLE_ALU;
                        o_bus_input_selector  <= r_uop.in_sel;
                        o_bus_output_selector <= r_uop.out_sel;
                        o_alu_op              <= r_uop.alu_op;
`ifdef UCODE_PREFETCH_EN
                        o_rom_addr            <= r_pc + ADDR_W'(1);
`endif
                    end
                    ST_ALU: begin
                        r_state               <= ST_WRITE;
                        o_current_cycle       <= CYCLE_REG_WRITE;
                        o_bus_input_selector  <= r_uop.in_sel;
                        o_bus_output_selector <= r_uop.out_sel;
                        o_alu_op              <= r_uop.alu_op;
                    end
                    ST_WRITE: begin
                        if (r_uop.last || w_last_step) begin
                            r_state               <= ST_IDLE;
                            o_current_cycle       <= CYCLE_NOOP;
                            o_bus_input_selector  <= REG_ALU;
                            o_bus_output_selector <= REG_ALU;
                            o_alu_op              <= '0;
                            o_busy                <= 1'b0;
                            o_done                <= 1'b1;
                            o_overrun             <= !r_uop.last;
                        end else begin
                            r_step <= r_step + STEP_W'(1);
                            r_pc   <= r_pc + ADDR_W'(1);
`ifdef UCODE_PREFETCH_EN
                            // ROM already returned the next word during WRITE
                            r_state               <= ST_FETCH;
                            r_uop                 <= w_rom_uop;
                            o_current_cycle       <= CYCLE_REG_FETCH;
                            o_bus_input_selector  <= w_rom_uop.in_sel;
                            o_bus_output_selector <= w_rom_uop.out_sel;
                            o_alu_op              <= w_rom_uop.alu_op;
`else
                            r_state               <= ST_ADDR;
                            o_rom_addr            <= r_pc + ADDR_W'(1);
                            o_current_cycle       <= CYCLE_NOOP;
                            o_bus_input_selector  <= REG_ALU;
                            o_bus_output_selector <= REG_ALU;
                            o_alu_op              <= '0;
`endif
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
Steps a register-transfer micro-op program held in a synchronous microcode ROM. Each fetched micro-op drives the register file's bus selectors, the ALU op and the microcode_cycle phase, in order. The block sits between instruction decode, which supplies the start address, and the register/ALU datapath. It owns the only drive of current_cycle.

Parameters:
ADDR_W, 8, microcode ROM address width
UOP_W, 16, micro-op word width
MAX_UOPS, 16, micro-ops allowed per program before forced abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch program; accepted only when busy=0
start_addr  in  ADDR_W  first micro-op address
stall  in  1  freeze all sequencing (memory/peripheral wait)
rom_addr  out  ADDR_W  ROM read address; data returns 1 cycle later
rom_data  in  UOP_W  ROM word: [15] last, [14:10] in_sel, [9:5] out_sel, [4] reserved (ignored), [3:0] alu_op
current_cycle  out  2  microcode_cycle phase to the register file
bus_input_selector  out  5  reg_type source
bus_output_selector  out  5  reg_type destination
alu_op  out  4  ALU operation for the current micro-op
busy  out  1  program in progress
done  out  1  1-cycle pulse after the final micro-op's write phase
overrun  out  1  sticky: program hit MAX_UOPS without last

Behaviour:
- Reset, asynchronous: state IDLE, rom_addr=0, current_cycle=CYCLE_NOOP, both selectors=REG_ALU, alu_op=0, busy=0, done=0, overrun=0, step count=0.
- Safe idle: outside REG_FETCH/ALU/REG_WRITE, both selectors = REG_ALU (invalid write target, so no register or memory write). alu_op=0.
- States: IDLE, ADDR, DECODE, FETCH, ALU, WRITE. current_cycle is CYCLE_NOOP in IDLE/ADDR/DECODE, CYCLE_REG_FETCH in FETCH, CYCLE_ALU in ALU, CYCLE_REG_WRITE in WRITE.
- Start: start=1 with busy=0 at edge T. rom_addr=start_addr and busy=1 from T+1. start is ignored while busy=1.
- Sequencing: ADDR -> DECODE. DECODE latches rom_data into the uop register, then -> FETCH -> ALU -> WRITE. Selectors and alu_op come from the uop register and are constant through FETCH..WRITE.
- From WRITE:
  - last=0: rom_addr+1 (wraps mod 2^ADDR_W), step count +1, -> ADDR.
  - last=1: -> IDLE. done=1 and busy=0 in the same cycle.
- Latency: 5 cycles per micro-op. A single-op program pulses done at T+6.
- Overrun: WRITE of the MAX_UOPS-th micro-op with last=0 -> IDLE, done=1, overrun=1. overrun clears when the next start is accepted.
- Stall: when stall=1 and state≠IDLE, state, rom_addr, uop register and all outputs hold. A done pulse is not stretched, because done is generated on the transition. Stall in IDLE has no effect; a start is still accepted.
- Simultaneous start and done cycle: start is accepted, since busy=0 in that cycle.
- Reset mid-program: immediate abort to reset values. No partial write phase is emitted after reset deasserts.

Optional Feature:
UCODE_PREFETCH_EN
- Defined: during ALU, rom_addr advances to pc+1. The word is captured into a prefetch register in WRITE. If last=0, the next micro-op goes WRITE -> FETCH directly, so 3 cycles per micro-op after the first. last, overrun and stall rules are unchanged; the prefetched word is discarded on last/overrun/reset.
- Undefined: 5 cycles per micro-op as above. No prefetch register exists.

Decomposition:
- Shared types package holds:
  - existing reg_type and microcode_cycle; microcode_cycle gains CYCLE_NOOP and CYCLE_ALU
  - new uop_t packed struct (last, in_sel, out_sel, rsvd, alu_op)
  - seq_state enum
  - UOP_LAST_BIT constant
- No sub-module. The block is one FSM plus pc/step counters.

Test Plan:
- Single op: ROM[0x10]={last=1, in=REG_A, out=REG_B, alu=3}, start_addr=0x10 -> cycles NOOP,NOOP,FETCH,ALU,WRITE; selectors A/B only in FETCH..WRITE; done at T+6; busy low after.
- Three-op program at 0x20 (last on 0x22) -> rom_addr 0x20,0x21,0x22; done once at T+16; overrun=0.
- No last bit and MAX_UOPS=16 from 0xF8 -> rom_addr wraps 0xFF->0x00; done with overrun=1 after 16 ops; next start clears overrun.
- stall=1 for 4 cycles during ALU of op 2 -> all outputs frozen; done delayed exactly 4 cycles.
- reset pulse during FETCH -> all outputs reset-valued asynchronously; selectors REG_ALU; no WRITE phase follows; start during busy ignored.
- With UCODE_PREFETCH_EN: three-op program -> done at T+12; identical selector sequence to the non-prefetch run.
